// File: rtl/pipeio_pkg.sv
// Shared definitions for the pipeline I/O responder: register word offsets
// within the I/O window and bit positions of the STATUS change flags.
package pipeio_pkg;

  localparam logic [5:0] W_IN0      = 6'd0;
  localparam logic [5:0] W_IN1      = 6'd1;
  localparam logic [5:0] W_IN2      = 6'd2;
  localparam logic [5:0] W_STATUS   = 6'd3;
  localparam logic [5:0] W_OUT0     = 6'd4;
  localparam logic [5:0] W_OUT1     = 6'd5;
  localparam logic [5:0] W_OUT2     = 6'd6;
  localparam logic [5:0] W_IRQ_MASK = 6'd7;

  localparam int unsigned ST_IN0 = 0;
  localparam int unsigned ST_IN1 = 1;
  localparam int unsigned ST_IN2 = 2;

  // Byte address to register word index; the low two address bits are ignored.
  function automatic logic [5:0] word_of(input logic [7:0] addr);
    return addr[7:2];
  endfunction

endpackage

// File: rtl/pipeio_debounce.sv
// Input conditioner for one switch port: two-flop synchroniser, a run-length
// counter and the debounced (stable) value. `change` is high in the cycle
// whose rising edge loads a new stable value.
module pipeio_debounce #(
  parameter int unsigned W         = 8,
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic [W-1:0] pin,
  output logic [W-1:0] stable,
  output logic         change
);

  localparam int unsigned     CW   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0]   TERM = CW'(DB_CYCLES - 1);

  logic [W-1:0]  sync1;
  logic [W-1:0]  sync2;
  logic [CW-1:0] cnt;

  assign change = (sync2 != stable) && (cnt == TERM);

  // Synchronise the pin, count consecutive cycles it differs from the stable
  // value, and accept it once the count reaches the terminal value.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      cnt    <= '0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == TERM) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/pipeio_responder.sv
// Memory-mapped I/O responder for the CPU data-memory stage: three debounced
// switch inputs, a clear-on-read STATUS change register and three latched
// output ports. Optional feature macro IO_IRQ_EN adds IRQ_MASK at 0x1C and a
// registered io_irq output.
module pipeio_responder
  import pipeio_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 16,
  parameter int unsigned IN0_W     = 8,
  parameter int unsigned IN1_W     = 8,
  parameter int unsigned IN2_W     = 2
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             io_we,
  input  logic             io_re,
  input  logic [7:0]       io_addr,
  input  logic [31:0]      io_wdata,
  output logic [31:0]      io_rdata,
  input  logic [IN0_W-1:0] in_pin0,
  input  logic [IN1_W-1:0] in_pin1,
  input  logic [IN2_W-1:0] in_pin2,
  output logic [31:0]      out_port0,
  output logic [31:0]      out_port1,
  output logic [31:0]      out_port2
`ifdef IO_IRQ_EN
  ,
  output logic             io_irq
`endif
);

  logic [IN0_W-1:0] in0;
  logic [IN1_W-1:0] in1;
  logic [IN2_W-1:0] in2;
  logic [2:0]       chg;
  logic [2:0]       status;
  logic [5:0]       word;
  logic             unused_addr;

  assign word        = word_of(io_addr);
  assign unused_addr = ^io_addr[1:0];

  pipeio_debounce #(.W(IN0_W), .DB_CYCLES(DB_CYCLES)) u_db0 (
    .clock(clock), .resetn(resetn), .pin(in_pin0), .stable(in0), .change(chg[ST_IN0])
  );
  pipeio_debounce #(.W(IN1_W), .DB_CYCLES(DB_CYCLES)) u_db1 (
    .clock(clock), .resetn(resetn), .pin(in_pin1), .stable(in1), .change(chg[ST_IN1])
  );
  pipeio_debounce #(.W(IN2_W), .DB_CYCLES(DB_CYCLES)) u_db2 (
    .clock(clock), .resetn(resetn), .pin(in_pin2), .stable(in2), .change(chg[ST_IN2])
  );

  // Change flags: a load of STATUS clears them, but a flag raised on the same edge survives.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      status <= '0;
    end else if (io_re && (word == W_STATUS)) begin
      status <= chg;
    end else begin
      status <= status | chg;
    end
  end

`ifdef IO_IRQ_EN
  logic [2:0] irq_mask;

  // Interrupt mask register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      irq_mask <= '0;
    end else if (io_we && (word == W_IRQ_MASK)) begin
      irq_mask <= io_wdata[2:0];
    end
  end

  // Interrupt line, registered from the current flags and mask.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      io_irq <= 1'b0;
    end else begin
      io_irq <= |(status & irq_mask);
    end
  end
`endif

  // Output ports latched from CPU stores; stores elsewhere are ignored.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_port0 <= '0;
      out_port1 <= '0;
      out_port2 <= '0;
    end else if (io_we) begin
      case (word)
        W_OUT0:  out_port0 <= io_wdata;
        W_OUT1:  out_port1 <= io_wdata;
        W_OUT2:  out_port2 <= io_wdata;
        default: ;
      endcase
    end
  end

  // Load data mux; unmapped words read zero.
  always_comb begin
    io_rdata = '0;
    case (word)
      W_IN0:      io_rdata = 32'(in0);
      W_IN1:      io_rdata = 32'(in1);
      W_IN2:      io_rdata = 32'(in2);
      W_STATUS:   io_rdata = {29'b0, status};
      W_OUT0:     io_rdata = out_port0;
      W_OUT1:     io_rdata = out_port1;
      W_OUT2:     io_rdata = out_port2;
`ifdef IO_IRQ_EN
      W_IRQ_MASK: io_rdata = {29'b0, irq_mask};
`endif
      default:    io_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_pipeio_responder.sv
// Self-checking bench for pipeio_responder: a queue-based model of the
// debounce/STATUS/register rules is compared every falling edge, and
// directed scenarios add literal expectations at the interesting cycles.
module tb_pipeio_responder;

  localparam int DB = 16;

  logic        clock = 1'b0;
  logic        resetn;
  logic        io_we, io_re;
  logic [7:0]  io_addr;
  logic [31:0] io_wdata, io_rdata;
  logic [7:0]  in_pin0, in_pin1;
  logic [1:0]  in_pin2;
  logic [31:0] out_port0, out_port1, out_port2;
`ifdef IO_IRQ_EN
  logic        io_irq;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic chk_en = 1'b0;

  pipeio_responder #(.DB_CYCLES(DB), .IN0_W(8), .IN1_W(8), .IN2_W(2)) dut (
    .clock(clock), .resetn(resetn), .io_we(io_we), .io_re(io_re),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata),
    .in_pin0(in_pin0), .in_pin1(in_pin1), .in_pin2(in_pin2),
    .out_port0(out_port0), .out_port1(out_port1), .out_port2(out_port2)
`ifdef IO_IRQ_EN
    , .io_irq(io_irq)
`endif
  );

  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  logic [31:0] m_out [3];
  logic [31:0] m_in  [3];
  logic [31:0] m_d1  [3];
  logic [31:0] m_d2  [3];
  logic [31:0] m_pend[3][$];
  logic [2:0]  m_st, m_mask, m_flags;
  logic        m_irq;
  logic [31:0] m_c;

  function automatic logic [31:0] pin_of(input int p);
    case (p)
      0:       return {24'b0, in_pin0};
      1:       return {24'b0, in_pin1};
      default: return {30'b0, in_pin2};
    endcase
  endfunction

  function automatic logic [31:0] exp_rd(input logic [7:0] a);
    case (a[7:2])
      6'd0: return m_in[0];
      6'd1: return m_in[1];
      6'd2: return m_in[2];
      6'd3: return {29'b0, m_st};
      6'd4: return m_out[0];
      6'd5: return m_out[1];
      6'd6: return m_out[2];
`ifdef IO_IRQ_EN
      6'd7: return {29'b0, m_mask};
`endif
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int p = 0; p < 3; p++) begin
        m_out[p] = '0; m_in[p] = '0; m_d1[p] = '0; m_d2[p] = '0;
        m_pend[p].delete();
      end
      m_st = '0; m_mask = '0; m_irq = 1'b0;
    end else begin
      m_irq   = |(m_st & m_mask);
      m_flags = '0;
      for (int p = 0; p < 3; p++) begin
        // value pin had two edges ago is what the filter sees now
        m_c     = m_d2[p];
        m_d2[p] = m_d1[p];
        m_d1[p] = pin_of(p);
        if (m_c == m_in[p]) begin
          m_pend[p].delete();
        end else begin
          m_pend[p].push_back(m_c);
          if (m_pend[p].size() == DB) begin
            m_in[p]    = m_c;
            m_flags[p] = 1'b1;
            m_pend[p].delete();
          end
        end
      end
      if (io_re && io_addr[7:2] == 6'd3) m_st = m_flags;
      else                               m_st = m_st | m_flags;
      if (io_we) begin
        case (io_addr[7:2])
          6'd4: m_out[0] = io_wdata;
          6'd5: m_out[1] = io_wdata;
          6'd6: m_out[2] = io_wdata;
`ifdef IO_IRQ_EN
          6'd7: m_mask = io_wdata[2:0];
`endif
          default: ;
        endcase
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check($sformatf("rdata@%h", io_addr), io_rdata, exp_rd(io_addr));
      check("out_port0", out_port0, m_out[0]);
      check("out_port1", out_port1, m_out[1]);
      check("out_port2", out_port2, m_out[2]);
`ifdef IO_IRQ_EN
      check("io_irq", {31'b0, io_irq}, {31'b0, m_irq});
`endif
    end
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic sample();
    @(negedge clock); #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    io_we = 1'b1; io_addr = a; io_wdata = d;
    step();
    io_we = 1'b0;
  endtask

  task automatic lit_rd(input string name, input logic [7:0] a, input logic [31:0] exp);
    io_addr = a; #1;
    check(name, io_rdata, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; io_we = 1'b0; io_re = 1'b0; io_addr = '0; io_wdata = '0;
    in_pin0 = '0; in_pin1 = '0; in_pin2 = '0;
    repeat (3) @(posedge clock);
    chk_en = 1'b1;
    step();
    resetn = 1'b1;

    // activity, then asynchronous reset mid-debounce
    wr(8'h10, 32'h11);
    in_pin1 = 8'h55;
    sample();
    check("out0 before reset", out_port0, 32'h11);
    repeat (8) step();
    #2 resetn = 1'b0;
    #1 check("out0 in reset", out_port0, 32'h0);
    lit_rd("status in reset", 8'h0C, 32'h0);
    in_pin1 = 8'h00;
    step(); step();
    resetn = 1'b1;
    repeat (20) step();
    sample();
    lit_rd("status after reset", 8'h0C, 32'h0);
    lit_rd("in1 after reset", 8'h04, 32'h0);

    // stores to OUT1 and to read-only / unmapped words
    step();
    wr(8'h14, 32'hA5);
    sample();
    check("out1 store", out_port1, 32'h0000_00A5);
    io_re = 1'b1;
    lit_rd("load out1", 8'h14, 32'hA5);
    step();
    io_re = 1'b0;
    wr(8'h04, 32'h0);
    wr(8'h00, 32'hFF);
    wr(8'h24, 32'hFFFF_FFFF);
    wr(8'h0C, 32'h7);
    wr(8'h1C, 32'h7);
    sample();
    check("out1 after ignored stores", out_port1, 32'hA5);
    lit_rd("in0 ro", 8'h00, 32'h0);
    lit_rd("status ro", 8'h0C, 32'h0);
    lit_rd("unmapped 0x24", 8'h24, 32'h0);
    lit_rd("addr lsbs ignored", 8'h17, 32'hA5);
`ifndef IO_IRQ_EN
    lit_rd("0x1C reads zero", 8'h1C, 32'h0);
`endif

    // debounce latency on port 0
    io_addr = 8'h00;
    step();
    in_pin0 = 8'h3C;
    repeat (2 + DB - 1) step();
    sample();
    lit_rd("in0 one cycle early", 8'h00, 32'h0);
    step();
    sample();
    lit_rd("in0 at 2+DB", 8'h00, 32'h3C);
    lit_rd("status port0", 8'h0C, 32'h1);

    // clear-on-read
    io_re = 1'b1;
    #1 check("load status old", io_rdata, 32'h1);
    step();
    io_re = 1'b0;
    sample();
    lit_rd("status cleared", 8'h0C, 32'h0);

    // short glitch on port 2 is discarded
    step();
    in_pin2 = 2'b11;
    repeat (DB - 2) step();
    in_pin2 = 2'b00;
    repeat (30) step();
    sample();
    lit_rd("in2 glitch", 8'h08, 32'h0);
    lit_rd("status glitch", 8'h0C, 32'h0);

    // clear coinciding with a new port-1 flag
    step();
    in_pin0 = 8'h00;
    repeat (5) step();
    in_pin1 = 8'h81;
    repeat (2 + DB - 1) step();
    io_re = 1'b1;
    lit_rd("status before clear", 8'h0C, 32'h1);
    step();
    io_re = 1'b0;
    sample();
    lit_rd("set wins over clear", 8'h0C, 32'h2);
    lit_rd("in1 new", 8'h04, 32'h81);
    lit_rd("in0 back to 0", 8'h00, 32'h0);

    // simultaneous store and load
    wr(8'h18, 32'h1234_5678);
    io_we = 1'b1; io_re = 1'b1; io_wdata = 32'hDEAD_BEEF;
    #1 check("we+re returns old", io_rdata, 32'h1234_5678);
    step();
    io_we = 1'b0; io_re = 1'b0;
    sample();
    check("we+re write applied", out_port2, 32'hDEAD_BEEF);

`ifdef IO_IRQ_EN
    wr(8'h1C, 32'h4);
    io_re = 1'b1; io_addr = 8'h0C;
    step();
    io_re = 1'b0;
    in_pin2 = 2'b01;
    repeat (2 + DB) step();
    sample();
    check("irq not yet", {31'b0, io_irq}, 32'h0);
    step();
    sample();
    check("irq raised", {31'b0, io_irq}, 32'h1);
    io_re = 1'b1;
    step();
    io_re = 1'b0;
    sample();
    check("irq still set on clear edge", {31'b0, io_irq}, 32'h1);
    step();
    sample();
    check("irq dropped", {31'b0, io_irq}, 32'h0);
`endif

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
